// File: rtl/clock_set_ctrl.sv
// Adjust-mode sequencer for the digital clock: MODE steps the adjust field,
// UP (with auto-repeat) pulses the selected field, idle timeout returns to normal.
module clock_set_ctrl #(
  parameter int TICK_DIV   = 100000,
  parameter int TIMEOUT_MS = 10000,
  parameter int RPT_DLY_MS = 500,
  parameter int RPT_PER_MS = 100,
  parameter int BLINK_MS   = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic [1:0] gt_mod,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       inc_hr,
  output logic       run_en,
  output logic       blink
);

  localparam logic [1:0] ST_NORMAL = 2'b00;

  localparam int RPT_MAX = (RPT_DLY_MS > RPT_PER_MS) ? RPT_DLY_MS : RPT_PER_MS;
  localparam int PW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
  localparam int IW = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS) : 1;
  localparam int HW = (RPT_MAX    > 1) ? $clog2(RPT_MAX)    : 1;
  localparam int BW = (BLINK_MS   > 1) ? $clog2(BLINK_MS)   : 1;

  // Counters run 0..N-1 and act on the tick that would make them reach N.
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT_MS - 1);
  localparam logic [HW-1:0] DLY_LAST   = HW'(RPT_DLY_MS - 1);
  localparam logic [HW-1:0] PER_LAST   = HW'(RPT_PER_MS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

  logic [PW-1:0] presc_reg, presc_next;
  logic [IW-1:0] idle_reg, idle_next;
  logic [HW-1:0] hold_reg, hold_next;
  logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
  logic [1:0]    state_reg, state_next;
  logic [2:0]    inc_reg, inc_next;
  logic          mode_prev_reg, up_prev_reg;
  logic          rpt_arm_reg, rpt_arm_next;
  logic          rpt_phase_reg, rpt_phase_next;
  logic          blink_reg, blink_next;
  logic          run_en_reg;

  logic tick, mode_ev, up_ev, adjusting, up_accept, rpt_fire, inc_any, timeout, state_chg;

  always_comb begin
    tick      = (presc_reg == PRESC_LAST);
    mode_ev   = btn_mode & ~mode_prev_reg;
    up_ev     = btn_up & ~up_prev_reg;
    adjusting = (state_reg != ST_NORMAL);
    // MODE has priority: a coincident UP edge is dropped.
    up_accept = adjusting & up_ev & ~mode_ev;
    rpt_fire  = adjusting & rpt_arm_reg & btn_up & ~mode_ev & tick &
                (rpt_phase_reg ? (hold_reg == PER_LAST) : (hold_reg == DLY_LAST));
    inc_any   = up_accept | rpt_fire;
    timeout   = adjusting & ~mode_ev & ~inc_any & tick & (idle_reg == IDLE_LAST);
    state_chg = mode_ev | timeout;

    presc_next = tick ? '0 : presc_reg + 1'b1;

    state_next = state_reg;
    if (mode_ev)      state_next = state_reg + 2'd1;
    else if (timeout) state_next = ST_NORMAL;

    idle_next = idle_reg;
    if (!adjusting || state_chg || up_ev || inc_any) idle_next = '0;
    else if (tick)                                   idle_next = idle_reg + 1'b1;

    // Repeat is armed only by an accepted UP edge, so a MODE during a hold
    // needs a fresh press before pulses resume.
    rpt_arm_next   = rpt_arm_reg;
    rpt_phase_next = rpt_phase_reg;
    hold_next      = hold_reg;
    if (!adjusting || state_chg || !btn_up) begin
      rpt_arm_next   = 1'b0;
      rpt_phase_next = 1'b0;
      hold_next      = '0;
    end else if (up_accept) begin
      rpt_arm_next   = 1'b1;
      rpt_phase_next = 1'b0;
      hold_next      = '0;
    end else if (rpt_fire) begin
      rpt_phase_next = 1'b1;
      hold_next      = '0;
    end else if (tick && rpt_arm_reg) begin
      hold_next      = hold_reg + 1'b1;
    end

    blink_cnt_next = blink_cnt_reg;
    blink_next     = blink_reg;
    if (!adjusting || state_chg || inc_any) begin
      blink_cnt_next = '0;
      blink_next     = 1'b1;
    end else if (tick) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_next = '0;
        blink_next     = ~blink_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + 1'b1;
      end
    end
  end

  // Bit gi of inc_next belongs to adjust state gi+1 (sec, min, hr).
  for (genvar gi = 0; gi < 3; gi++) begin : g_inc
    assign inc_next[gi] = inc_any & (state_reg == 2'(gi + 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg     <= '0;
      idle_reg      <= '0;
      hold_reg      <= '0;
      blink_cnt_reg <= '0;
      state_reg     <= ST_NORMAL;
      inc_reg       <= '0;
      mode_prev_reg <= 1'b1;
      up_prev_reg   <= 1'b1;
      rpt_arm_reg   <= 1'b0;
      rpt_phase_reg <= 1'b0;
      blink_reg     <= 1'b1;
      run_en_reg    <= 1'b1;
    end else begin
      presc_reg     <= presc_next;
      idle_reg      <= idle_next;
      hold_reg      <= hold_next;
      blink_cnt_reg <= blink_cnt_next;
      state_reg     <= state_next;
      inc_reg       <= inc_next;
      mode_prev_reg <= btn_mode;
      up_prev_reg   <= btn_up;
      rpt_arm_reg   <= rpt_arm_next;
      rpt_phase_reg <= rpt_phase_next;
      blink_reg     <= blink_next;
      run_en_reg    <= (state_next == ST_NORMAL);
    end
  end

  assign gt_mod  = state_reg;
  assign inc_sec = inc_reg[0];
  assign inc_min = inc_reg[1];
  assign inc_hr  = inc_reg[2];
  assign run_en  = run_en_reg;
  assign blink   = blink_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: vector table for MODE/UP stepping, a pulse
// scoreboard for every inc_* output, and timed sequences for repeat/timeout/blink.
module tb_clock_set_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int TIMEOUT_MS = 20;
  localparam int RPT_DLY_MS = 5;
  localparam int RPT_PER_MS = 2;
  localparam int BLINK_MS   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic [1:0] gt_mod;
  logic       inc_sec, inc_min, inc_hr, run_en, blink;

  clock_set_ctrl #(
    .TICK_DIV(TICK_DIV), .TIMEOUT_MS(TIMEOUT_MS), .RPT_DLY_MS(RPT_DLY_MS),
    .RPT_PER_MS(RPT_PER_MS), .BLINK_MS(BLINK_MS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_up(btn_up),
    .gt_mod(gt_mod), .inc_sec(inc_sec), .inc_min(inc_min), .inc_hr(inc_hr),
    .run_en(run_en), .blink(blink)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [2:0] exp_q[$];   // expected {hr,min,sec} of each upcoming pulse
  int pulse_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Every inc pulse seen must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n && (inc_sec || inc_min || inc_hr)) begin
      pulse_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_inc", int'({inc_hr, inc_min, inc_sec}), 0);
      else                   check("inc_kind", int'({inc_hr, inc_min, inc_sec}), int'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic       is_up;
    logic [1:0] exp_gt;
    logic       exp_run;
    logic [2:0] exp_inc;
  } vec_t;

  vec_t vec[12];

  task automatic mode_press(output int ev);
    @(negedge clk) btn_mode = 1'b1;
    @(posedge clk); #1;
    ev = cyc;
    @(negedge clk) btn_mode = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_blink_change(input int limit, output int when);
    logic b0;
    int t;
    b0 = blink;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (blink == b0 && t < limit);
    when = (blink == b0) ? -1000 : cyc;
  endtask

  initial begin
    int e, e2, t, t1, t2, t3, t4;

    vec[0]  = '{1'b0, 2'b01, 1'b0, 3'b000};
    vec[1]  = '{1'b0, 2'b10, 1'b0, 3'b000};
    vec[2]  = '{1'b1, 2'b10, 1'b0, 3'b010};
    vec[3]  = '{1'b0, 2'b11, 1'b0, 3'b000};
    vec[4]  = '{1'b0, 2'b00, 1'b1, 3'b000};
    vec[5]  = '{1'b1, 2'b00, 1'b1, 3'b000};
    vec[6]  = '{1'b0, 2'b01, 1'b0, 3'b000};
    vec[7]  = '{1'b1, 2'b01, 1'b0, 3'b001};
    vec[8]  = '{1'b0, 2'b10, 1'b0, 3'b000};
    vec[9]  = '{1'b0, 2'b11, 1'b0, 3'b000};
    vec[10] = '{1'b1, 2'b11, 1'b0, 3'b100};
    vec[11] = '{1'b0, 2'b00, 1'b1, 3'b000};

    // Reset with both buttons held: release of reset must not create events.
    btn_mode = 1'b1;
    btn_up   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_gt", gt_mod, 0);
    check("reset_run", run_en, 1);
    check("reset_blink", blink, 1);
    check("reset_inc", {inc_hr, inc_min, inc_sec}, 0);
    @(negedge clk) begin btn_mode = 1'b0; btn_up = 1'b0; end
    repeat (5) @(posedge clk);

    // MODE stepping and single UP presses, including UP in NORMAL.
    for (int i = 0; i < 12; i++) begin
      if (vec[i].exp_inc != 3'b000) exp_q.push_back(vec[i].exp_inc);
      @(negedge clk);
      if (vec[i].is_up) btn_up = 1'b1;
      else              btn_mode = 1'b1;
      @(posedge clk); #1;
      check($sformatf("vec%0d_gt", i), gt_mod, vec[i].exp_gt);
      check($sformatf("vec%0d_run", i), run_en, vec[i].exp_run);
      check($sformatf("vec%0d_inc", i), {inc_hr, inc_min, inc_sec}, vec[i].exp_inc);
      repeat (vec[i].is_up ? 2 : 0) @(posedge clk);
      @(negedge clk) begin btn_mode = 1'b0; btn_up = 1'b0; end
      repeat (8) @(posedge clk);
    end

    // Auto-repeat: 40 clk hold in SEC gives pulses at edge+1 and ticks 5, 7, 9.
    mode_press(e);
    pulse_cyc.delete();
    repeat (4) exp_q.push_back(3'b001);
    @(negedge clk) btn_up = 1'b1;
    @(posedge clk); #1;
    e = cyc;
    repeat (39) @(posedge clk);
    @(negedge clk) btn_up = 1'b0;
    repeat (20) @(posedge clk);
    check("rpt_count", pulse_cyc.size(), 4);
    if (pulse_cyc.size() >= 4) begin
      check("rpt_first_lat", pulse_cyc[0] - e, 0);
      t = pulse_cyc[1] - e;
      check("rpt_delay_in_13_20", int'(t >= 13 && t <= 20), 1);
      check("rpt_period1", pulse_cyc[2] - pulse_cyc[1], 8);
      check("rpt_period2", pulse_cyc[3] - pulse_cyc[2], 8);
    end

    // Timeout from HR with no activity.
    mode_press(e);
    mode_press(e);
    check("hr_gt", gt_mod, 3);
    t = 0;
    while (gt_mod != 2'b00 && t < 120) begin
      @(negedge clk);
      t++;
    end
    check("timeout_gt", gt_mod, 0);
    check("timeout_run", run_en, 1);
    t = cyc - e;
    check("timeout_in_76_84", int'(t >= 76 && t <= 84), 1);

    // MODE and UP together: MODE wins, and holding UP does not repeat.
    mode_press(e);
    pulse_cyc.delete();
    @(negedge clk) begin btn_mode = 1'b1; btn_up = 1'b1; end
    @(posedge clk); #1;
    check("simul_gt", gt_mod, 2);
    check("simul_inc", {inc_hr, inc_min, inc_sec}, 0);
    @(negedge clk) btn_mode = 1'b0;
    repeat (40) @(posedge clk);
    check("simul_no_repeat", pulse_cyc.size(), 0);
    @(negedge clk) btn_up = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.push_back(3'b010);
    @(negedge clk) btn_up = 1'b1;
    @(posedge clk); #1;
    check("repress_inc", {inc_hr, inc_min, inc_sec}, 3'b010);
    @(negedge clk) btn_up = 1'b0;
    repeat (3) @(posedge clk);

    // Blink in SEC, restart on UP, then asynchronous reset.
    mode_press(e);
    mode_press(e);
    mode_press(e);
    check("blink_state_gt", gt_mod, 1);
    wait_blink_change(20, t1);
    t = t1 - e;
    check("blink_first_in_5_12", int'(t >= 5 && t <= 12), 1);
    wait_blink_change(20, t2);
    check("blink_half_period1", t2 - t1, 12);
    wait_blink_change(20, t3);
    check("blink_half_period2", t3 - t2, 12);
    check("blink_low_before_up", blink, 0);
    exp_q.push_back(3'b001);
    @(negedge clk) btn_up = 1'b1;
    @(posedge clk); #1;
    e2 = cyc;
    check("up_forces_blink", blink, 1);
    @(negedge clk) btn_up = 1'b0;
    wait_blink_change(20, t4);
    t = t4 - e2;
    check("blink_restart_in_5_12", int'(t >= 5 && t <= 12), 1);
    check("pre_reset_blink", blink, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_gt", gt_mod, 0);
    check("async_rst_blink", blink, 1);
    check("async_rst_run", run_en, 1);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("post_rst_gt", gt_mod, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
